// File: rtl/state_dump_unit.sv
`default_nettype none
// ============================================================================
//  Module   : state_dump_unit
//  Purpose  : Architectural-state dump engine for the pipelined MIPS core.
//             On a start pulse it halts the pipeline, waits for in-flight
//             writes to drain, then walks every register-file entry and
//             every data-memory word through spare read ports.
//             Each word leaves on a valid/ready stream with its source and index.
//  Ports    : clk_i/rst_ni      clock, asynchronous active-low reset
//             start_i/abort_i   begin a dump / cancel a dump
//             halt_o/busy_o     pipeline freeze, engine active
//             rf_addr_o/rf_data_i    register-file read port (combinational)
//             mem_addr_o/mem_data_i  data-memory read port (one-cycle latency)
//             dump_*            outgoing word stream (valid/ready)
//             done_o            one-cycle pulse after the last word is accepted
//  Revision : 1.0  initial release
// ============================================================================
module state_dump_unit #(
    parameter int DW           = 32,
    parameter int REG_AW       = 5,
    parameter int NREGS        = 32,
    parameter int MEM_AW       = 6,
    parameter int NMEM         = 64,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              halt_o,
    output logic              busy_o,
    output logic [REG_AW-1:0] rf_addr_o,
    input  logic [DW-1:0]     rf_data_i,
    output logic [MEM_AW-1:0] mem_addr_o,
    input  logic [DW-1:0]     mem_data_i,
    output logic              dump_valid_o,
    input  logic              dump_ready_i,
    output logic [DW-1:0]     dump_data_o,
    output logic              dump_src_o,
    output logic [MEM_AW-1:0] dump_idx_o,
    output logic              dump_last_o,
    output logic              done_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRAIN   = 3'd1,
        S_FETCH   = 3'd2,
        S_MWAIT   = 3'd3,
        S_PRESENT = 3'd4,
        S_DONE    = 3'd5
    } state_e;

    localparam int                CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [MEM_AW-1:0] LAST_REG = MEM_AW'(NREGS - 1);
    localparam logic [MEM_AW-1:0] LAST_MEM = MEM_AW'(NMEM - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [MEM_AW-1:0] idx_q,   idx_d;
    logic              sel_q,   sel_d;    // 0 = register file, 1 = data memory
    logic [DW-1:0]     data_q,  data_d;
    logic              last_word;

    assign last_word = sel_q && (idx_q == LAST_MEM);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sel_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_DRAIN;
                    cnt_d   = CNT_INIT;
                    sel_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            S_DRAIN: begin
                if (cnt_q == '0) begin
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_FETCH: begin
                // Register file reads combinationally; memory needs one more cycle.
                if (!sel_q) begin
                    data_d  = rf_data_i;
                    state_d = S_PRESENT;
                end else begin
                    state_d = S_MWAIT;
                end
            end
            S_MWAIT: begin
                data_d  = mem_data_i;
                state_d = S_PRESENT;
            end
            S_PRESENT: begin
                if (dump_ready_i) begin
                    if (last_word) begin
                        state_d = S_DONE;
                    end else if (!sel_q && (idx_q == LAST_REG)) begin
                        sel_d   = 1'b1;
                        idx_d   = '0;
                        state_d = S_FETCH;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides everything, including a start seen in IDLE.
        if (abort_i) begin
            state_d = S_IDLE;
        end
    end

    assign halt_o       = (state_q == S_DRAIN) || (state_q == S_FETCH) ||
                          (state_q == S_MWAIT) || (state_q == S_PRESENT);
    assign busy_o       = (state_q != S_IDLE);
    assign rf_addr_o    = idx_q[REG_AW-1:0];
    assign mem_addr_o   = idx_q;
    assign dump_valid_o = (state_q == S_PRESENT);
    assign dump_data_o  = data_q;
    assign dump_src_o   = sel_q;
    assign dump_idx_o   = idx_q;
    assign dump_last_o  = (state_q == S_PRESENT) && last_word;
    assign done_o       = (state_q == S_DONE);

endmodule
`default_nettype wire
